// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage in front of the instruction cache.
// Owns the PC, issues one word-aligned fetch at a time, buffers returned
// instructions in a small circular fetch queue and hands them to decode.
// Redirects flush the queue; an in-flight cache access is allowed to finish
// (its data is dropped) before fetching restarts at the new PC.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ic_req,
  output logic [31:0] ic_address,
  input  logic        ic_hit,
  input  logic [31:0] ic_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DROP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        pend_q, pend_d;
  logic [31:0]        addr_q, addr_d;
  logic               req_q;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   count_after;
  logic [31:0]        fq_pc_q    [FQ_DEPTH];
  logic [31:0]        fq_instr_q [FQ_DEPTH];

  logic [31:0]        redir_pc_w;
  logic               enq;
  logic               deq;
  logic               unused_redirect_low_bits;

  // The low two bits of a redirect target are meaningless for word fetches.
  assign redir_pc_w = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_low_bits = ^redirect_pc[1:0];

  // Queue head is presented straight from the registered queue state.
  assign if_valid   = (count_q != '0);
  assign if_pc      = if_valid ? fq_pc_q[rd_ptr_q]    : 32'h0;
  assign if_instr   = if_valid ? fq_instr_q[rd_ptr_q] : 32'h0;
  assign ic_req     = req_q;
  assign ic_address = addr_q;

  assign deq         = if_valid && if_ready;
  assign count_after = count_q + CNT_W'(1) - CNT_W'(deq);

  // Next-state logic: redirect first, otherwise normal fetch sequencing.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    addr_d   = addr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    enq      = 1'b0;

    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      unique case (state_q)
        IDLE: begin
          pc_d    = redir_pc_w;
          addr_d  = redir_pc_w;
          state_d = ISSUE;
        end
        ISSUE: begin
          pend_d  = redir_pc_w;
          state_d = DROP;
        end
        WAIT, DROP: begin
          if (ic_hit) begin
            pc_d    = redir_pc_w;
            addr_d  = redir_pc_w;
            state_d = ISSUE;
          end else begin
            pend_d  = redir_pc_w;
            state_d = DROP;
          end
        end
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (count_q < DEPTH_C) begin
            addr_d  = pc_q;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          state_d = WAIT;
        end
        WAIT: begin
          if (ic_hit) begin
            enq  = 1'b1;
            pc_d = addr_q + 32'd4;
            if (count_after < DEPTH_C) begin
              addr_d  = addr_q + 32'd4;
              state_d = ISSUE;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DROP: begin
          if (ic_hit) begin
            pc_d    = pend_q;
            addr_d  = pend_q;
            state_d = ISSUE;
          end
        end
      endcase

      if (enq) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state, PC bookkeeping and the registered cache request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      pend_q   <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      addr_q   <= addr_d;
      req_q    <= (state_d != IDLE);
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage; contents only matter while counted as valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      fq_pc_q[wr_ptr_q]    <= addr_q;
      fq_instr_q[wr_ptr_q] <= ic_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed bench for ifetch_unit. The bench plays the cache,
// keeps a transaction-level model of fetches and the fetch queue, and checks
// the DUT against it every cycle, plus literal checks per scenario.
module tb_ifetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        ic_req;
  logic [31:0] ic_address;
  logic        ic_hit;
  logic [31:0] ic_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  ifetch_unit #(.RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .ic_req         (ic_req),
    .ic_address     (ic_address),
    .ic_hit         (ic_hit),
    .ic_rdata       (ic_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Model: queued entries plus the single outstanding fetch, if any.
  entry_t      modelQ[$];
  bit          modelBusy;
  bit          modelDropping;
  int          modelAge;
  logic [31:0] modelAddr;
  logic [31:0] modelPend;
  logic [31:0] modelNextPc;

  // Stimulus controls.
  bit          resetIn;
  bit          readyIn;
  bit          redirIn;
  logic [31:0] redirPcIn;
  int          hitDelay;

  // Observed deliveries and request statistics.
  logic [31:0] logPc[$];
  logic [31:0] logInstr[$];
  int          logCycle[$];
  int          cycleNo;
  int          reqAtZero;
  int          reqStarts;
  logic        prevReq;
  logic [31:0] prevAddr;

  int nChecks;
  int nFails;

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  function automatic logic [31:0] logPcAt(input int i);
    if (i < logPc.size()) return logPc[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] logInstrAt(input int i);
    if (i < logInstr.size()) return logInstr[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycleNo);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelBusy     = 1'b0;
    modelDropping = 1'b0;
    modelAge      = 0;
    modelAddr     = RST_PC;
    modelPend     = RST_PC;
    modelNextPc   = RST_PC;
  endtask

  task automatic clearLogs();
    logPc.delete();
    logInstr.delete();
    logCycle.delete();
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic applyStimulus();
    bit hitNow;
    bit accepted;
    bit deqNow;
    bit hadRoom;
    @(negedge clk);
    cycleNo++;

    checkOutput("ic_req", 32'(ic_req), 32'(modelBusy));
    if (modelBusy) checkOutput("ic_address", ic_address, modelAddr);
    checkOutput("if_valid", 32'(if_valid), 32'(modelQ.size() != 0));
    if (modelQ.size() != 0) begin
      checkOutput("if_pc", if_pc, modelQ[0].pc);
      checkOutput("if_instr", if_instr, modelQ[0].instr);
    end

    if (ic_req === 1'b1 && ic_address === 32'h0) reqAtZero++;
    if (ic_req === 1'b1 && (prevReq !== 1'b1 || ic_address !== prevAddr)) reqStarts++;
    prevReq  = ic_req;
    prevAddr = ic_address;

    hitNow         = modelBusy && (modelAge >= hitDelay);
    reset          = resetIn;
    if_ready       = readyIn;
    redirect_valid = redirIn;
    redirect_pc    = redirPcIn;
    ic_hit         = hitNow;
    ic_rdata       = hitNow ? instrOf(ic_address) : $urandom();

    if (!resetIn && !redirIn && if_valid === 1'b1 && readyIn) begin
      logPc.push_back(if_pc);
      logInstr.push_back(if_instr);
      logCycle.push_back(cycleNo);
    end

    accepted = modelBusy && (modelAge >= 1) && hitNow;
    deqNow   = (modelQ.size() != 0) && readyIn;
    if (resetIn) begin
      modelReset();
    end else if (redirIn) begin
      modelQ.delete();
      if (modelBusy && !accepted) begin
        modelDropping = 1'b1;
        modelPend     = {redirPcIn[31:2], 2'b00};
        modelAge++;
      end else begin
        modelBusy     = 1'b1;
        modelDropping = 1'b0;
        modelAge      = 0;
        modelAddr     = {redirPcIn[31:2], 2'b00};
      end
    end else begin
      hadRoom = modelQ.size() < DEPTH;
      if (deqNow) void'(modelQ.pop_front());
      if (accepted) begin
        if (modelDropping) begin
          modelDropping = 1'b0;
          modelAddr     = modelPend;
          modelAge      = 0;
        end else begin
          modelQ.push_back('{pc: modelAddr, instr: instrOf(modelAddr)});
          if (modelQ.size() < DEPTH) begin
            modelAddr = modelAddr + 32'd4;
            modelAge  = 0;
          end else begin
            modelBusy   = 1'b0;
            modelNextPc = modelAddr + 32'd4;
          end
        end
      end else if (modelBusy) begin
        modelAge++;
      end else if (hadRoom) begin
        modelBusy = 1'b1;
        modelAge  = 0;
        modelAddr = modelNextPc;
      end
    end
    redirIn = 1'b0;
  endtask

  task automatic doReset();
    resetIn  = 1'b1;
    readyIn  = 1'b0;
    redirIn  = 1'b0;
    hitDelay = 1;
    repeat (2) applyStimulus();
    resetIn = 1'b0;
    clearLogs();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    int guard;
    nChecks = 0;
    nFails  = 0;
    cycleNo = 0;
    reqAtZero = 0;
    reqStarts = 0;
    prevReq   = 1'b0;
    prevAddr  = 32'h0;
    redirPcIn = 32'h0;
    reset          = 1'b1;
    if_ready       = 1'b0;
    ic_hit         = 1'b0;
    ic_rdata       = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    resetIn = 1'b1;
    readyIn = 1'b0;
    redirIn = 1'b0;
    hitDelay = 1;
    repeat (2) @(posedge clk);
    modelReset();

    // Reset values and free-running fetch; a hit during ISSUE must be ignored.
    doReset();
    checkOutput("reset ic_req", 32'(ic_req), 32'd0);
    checkOutput("reset ic_address", ic_address, RST_PC);
    checkOutput("reset if_valid", 32'(if_valid), 32'd0);
    checkOutput("reset if_pc", if_pc, 32'h0);
    checkOutput("reset if_instr", if_instr, 32'h0);
    readyIn  = 1'b1;
    hitDelay = 0;
    runCycles(12);
    for (int i = 0; i < 4; i++) begin
      checkOutput("free pc", logPcAt(i), 32'(4 * i));
      checkOutput("free instr", logInstrAt(i), instrOf(32'(4 * i)));
    end
    for (int i = 1; i < 4; i++) begin
      checkOutput("free spacing",
                  (i < logCycle.size()) ? 32'(logCycle[i] - logCycle[i-1]) : 32'hFFFF_FFFF, 32'd2);
    end

    // Backpressure: queue fills to four, requests stop, then drains in order.
    doReset();
    reqStarts = 0;
    readyIn = 1'b0;
    runCycles(14);
    checkOutput("bp request count", 32'(reqStarts), 32'd4);
    checkOutput("bp ic_req idle", 32'(ic_req), 32'd0);
    checkOutput("bp if_valid", 32'(if_valid), 32'd1);
    checkOutput("bp head pc", if_pc, 32'h0);
    readyIn = 1'b1;
    runCycles(12);
    for (int i = 0; i < 5; i++) checkOutput("bp drain pc", logPcAt(i), 32'(4 * i));

    // Miss latency: hit only after five WAIT-side cycles.
    doReset();
    reqAtZero = 0;
    readyIn  = 1'b1;
    hitDelay = 5;
    runCycles(12);
    checkOutput("miss req cycles", 32'(reqAtZero), 32'd6);
    checkOutput("miss enqueue count", 32'(logPc.size()), 32'd1);
    checkOutput("miss pc", logPcAt(0), 32'h0);

    // Redirect while idle with a full queue.
    doReset();
    readyIn = 1'b0;
    runCycles(12);
    checkOutput("idle full ic_req", 32'(ic_req), 32'd0);
    redirIn   = 1'b1;
    redirPcIn = 32'h0000_1003;
    applyStimulus();
    applyStimulus();
    checkOutput("idle redir if_valid", 32'(if_valid), 32'd0);
    checkOutput("idle redir ic_req", 32'(ic_req), 32'd1);
    checkOutput("idle redir ic_address", ic_address, 32'h0000_1000);
    clearLogs();
    readyIn = 1'b1;
    runCycles(6);
    checkOutput("idle redir first pc", logPcAt(0), 32'h0000_1000);

    // Redirect in WAIT, second redirect while dropping, hit three cycles later.
    doReset();
    readyIn  = 1'b1;
    hitDelay = 1000;
    guard = 0;
    while (!(modelBusy && modelAge == 1) && guard < 20) begin
      applyStimulus();
      guard++;
    end
    checkOutput("drop reach wait", 32'(guard < 20), 32'd1);
    redirIn   = 1'b1;
    redirPcIn = 32'h0000_2000;
    applyStimulus();
    redirIn   = 1'b1;
    redirPcIn = 32'h0000_3000;
    applyStimulus();
    hitDelay = 4;
    applyStimulus();
    checkOutput("drop hold addr", ic_address, 32'h0);
    checkOutput("drop hold req", 32'(ic_req), 32'd1);
    checkOutput("drop if_valid", 32'(if_valid), 32'd0);
    applyStimulus();
    hitDelay = 1;
    applyStimulus();
    checkOutput("drop restart addr", ic_address, 32'h0000_3000);
    clearLogs();
    runCycles(8);
    checkOutput("drop first pc", logPcAt(0), 32'h0000_3000);
    checkOutput("drop second pc", logPcAt(1), 32'h0000_3004);

    // Redirect coinciding with a hit and a dequeue, into the PC wrap point.
    doReset();
    readyIn = 1'b0;
    guard = 0;
    while (!(modelQ.size() == 2 && modelBusy && modelAge == 1) && guard < 20) begin
      applyStimulus();
      guard++;
    end
    checkOutput("coinc reach wait", 32'(guard < 20), 32'd1);
    clearLogs();
    readyIn   = 1'b1;
    redirIn   = 1'b1;
    redirPcIn = 32'hFFFF_FFFE;
    applyStimulus();
    applyStimulus();
    checkOutput("coinc if_valid", 32'(if_valid), 32'd0);
    checkOutput("coinc ic_req", 32'(ic_req), 32'd1);
    checkOutput("coinc ic_address", ic_address, 32'hFFFF_FFFC);
    runCycles(8);
    checkOutput("wrap first pc", logPcAt(0), 32'hFFFF_FFFC);
    checkOutput("wrap first instr", logInstrAt(0), instrOf(32'hFFFF_FFFC));
    checkOutput("wrap second pc", logPcAt(1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
